// File: rtl/rob_retire_multi.sv
// Reorder buffer with multi-lane in-order retire; allocate/writeback take effect next edge, retire is combinational off registered state.
// Backpressure: alloc_ready drops when full or flushing; a head store stalls retirement until st_ready.
module rob_retire_multi #(
    parameter int DEPTH        = 16,
    parameter int WB_PORTS     = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int PC_W         = 32,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic                          alloc_has_dest,
    input  logic                          alloc_is_store,
    input  logic [TAG_W-1:0]              alloc_dest,
    input  logic [TAG_W-1:0]              alloc_old,
    output logic [IDX_W-1:0]              alloc_idx,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]     wb_idx,
    input  logic [WB_PORTS*DATA_W-1:0]    wb_value,
    input  logic [WB_PORTS-1:0]           wb_mispredict,
    input  logic [WB_PORTS*PC_W-1:0]      wb_target,
    output logic [RETIRE_WIDTH-1:0]       ret_valid,
    output logic [RETIRE_WIDTH*TAG_W-1:0] ret_dest,
    output logic [RETIRE_WIDTH*TAG_W-1:0] ret_free,
    output logic [RETIRE_WIDTH*DATA_W-1:0] ret_value,
    output logic [RETIRE_WIDTH-1:0]       ret_wr_en,
    output logic                          st_valid,
    input  logic                          st_ready,
    output logic                          flush_valid,
    output logic [PC_W-1:0]               flush_pc,
    output logic [IDX_W:0]                count
);

    logic [IDX_W:0]     head, tail;
    logic [IDX_W-1:0]   head_idx, tail_idx;
    logic [DEPTH-1:0]   ent_valid, ent_done, ent_has_dest, ent_is_store, ent_mispredict;
    logic [TAG_W-1:0]   ent_dest   [DEPTH];
    logic [TAG_W-1:0]   ent_old    [DEPTH];
    logic [DATA_W-1:0]  ent_value  [DEPTH];
    logic [PC_W-1:0]    ent_target [DEPTH];
    logic [IDX_W-1:0]   lane_idx   [RETIRE_WIDTH];
    logic [IDX_W:0]     ret_cnt;
    logic               chain_ok;
    logic               alloc_fire;

    assign head_idx    = head[IDX_W-1:0];
    assign tail_idx    = tail[IDX_W-1:0];
    assign count       = tail - head;
    assign alloc_ready = (count != (IDX_W+1)'(DEPTH)) && !flush_valid;
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign st_valid    = ent_valid[head_idx] && ent_done[head_idx] && ent_is_store[head_idx];

    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            lane_idx[k] = head_idx + IDX_W'(k);
        end
    end

    // Lanes retire as an unbroken prefix from head; a store or mispredict ends the prefix.
    always_comb begin
        ret_valid   = '0;
        ret_wr_en   = '0;
        ret_dest    = '0;
        ret_free    = '0;
        ret_value   = '0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        ret_cnt     = '0;
        chain_ok    = 1'b1;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (chain_ok && (k < int'(count)) &&
                ent_valid[lane_idx[k]] && ent_done[lane_idx[k]] &&
                ((k == 0) ? (!ent_is_store[lane_idx[k]] || st_ready)
                          : !ent_is_store[lane_idx[k]])) begin
                ret_valid[k]                  = 1'b1;
                ret_wr_en[k]                  = ent_has_dest[lane_idx[k]] && !ent_is_store[lane_idx[k]];
                ret_dest[k*TAG_W +: TAG_W]    = ent_dest[lane_idx[k]];
                ret_free[k*TAG_W +: TAG_W]    = ent_old[lane_idx[k]];
                ret_value[k*DATA_W +: DATA_W] = ent_value[lane_idx[k]];
                ret_cnt                       = (IDX_W+1)'(k + 1);
                if (ent_mispredict[lane_idx[k]]) begin
                    flush_valid = 1'b1;
                    flush_pc    = ent_target[lane_idx[k]];
                    chain_ok    = 1'b0;
                end
                if (ent_is_store[lane_idx[k]]) begin
                    chain_ok = 1'b0;
                end
            end else begin
                chain_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && ent_valid[wb_idx[p*IDX_W +: IDX_W]]) begin
                    ent_done[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (ret_valid[k]) begin
                    ent_valid[lane_idx[k]] <= 1'b0;
                    ent_done[lane_idx[k]]  <= 1'b0;
                end
            end
            if (alloc_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                tail                <= tail + 1'b1;
            end
            head <= head + ret_cnt;
            // The mispredicting lane is always the last retired, so head + ret_cnt is one past it.
            if (flush_valid) begin
                ent_valid <= '0;
                ent_done  <= '0;
                tail      <= head + ret_cnt;
            end
        end
    end

    // Payload needs no reset: it is only observed behind valid/done.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && ent_valid[wb_idx[p*IDX_W +: IDX_W]]) begin
                ent_value[wb_idx[p*IDX_W +: IDX_W]]      <= wb_value[p*DATA_W +: DATA_W];
                ent_mispredict[wb_idx[p*IDX_W +: IDX_W]] <= wb_mispredict[p];
                ent_target[wb_idx[p*IDX_W +: IDX_W]]     <= wb_target[p*PC_W +: PC_W];
            end
        end
        if (alloc_fire) begin
            ent_has_dest[tail_idx]   <= alloc_has_dest;
            ent_is_store[tail_idx]   <= alloc_is_store;
            ent_dest[tail_idx]       <= alloc_dest;
            ent_old[tail_idx]        <= alloc_old;
            ent_mispredict[tail_idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_retire_multi.sv
// Directed bench for rob_retire_multi with DEPTH=16, two writeback ports, two retire lanes.
module tb_rob_retire_multi;
    localparam int DEPTH = 16;
    localparam int WBP   = 2;
    localparam int RW    = 2;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int PW    = 32;
    localparam int IW    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alloc_valid, alloc_ready, alloc_has_dest, alloc_is_store;
    logic [TW-1:0]     alloc_dest, alloc_old;
    logic [IW-1:0]     alloc_idx;
    logic [WBP-1:0]    wb_valid, wb_mispredict;
    logic [WBP*IW-1:0] wb_idx;
    logic [WBP*DW-1:0] wb_value;
    logic [WBP*PW-1:0] wb_target;
    logic [RW-1:0]     ret_valid, ret_wr_en;
    logic [RW*TW-1:0]  ret_dest, ret_free;
    logic [RW*DW-1:0]  ret_value;
    logic              st_valid, st_ready, flush_valid;
    logic [PW-1:0]     flush_pc;
    logic [IW:0]       count;

    int n_chk  = 0;
    int n_fail = 0;

    rob_retire_multi #(.DEPTH(DEPTH), .WB_PORTS(WBP), .RETIRE_WIDTH(RW),
                       .DATA_W(DW), .TAG_W(TW), .PC_W(PW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_is_store(alloc_is_store),
        .alloc_dest(alloc_dest), .alloc_old(alloc_old), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .ret_valid(ret_valid), .ret_dest(ret_dest), .ret_free(ret_free),
        .ret_value(ret_value), .ret_wr_en(ret_wr_en),
        .st_valid(st_valid), .st_ready(st_ready),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired: n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alloc_valid = 0; alloc_has_dest = 0; alloc_is_store = 0;
        alloc_dest = '0; alloc_old = '0;
        wb_valid = '0; wb_idx = '0; wb_value = '0; wb_mispredict = '0; wb_target = '0;
        st_ready = 0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 0;
        cyc(); cyc();
        rst = 1;
    endtask

    task automatic set_alloc(input logic hd, input logic st, input logic [TW-1:0] d, input logic [TW-1:0] o);
        alloc_valid = 1; alloc_has_dest = hd; alloc_is_store = st;
        alloc_dest = d; alloc_old = o;
    endtask

    task automatic set_wb(input int p, input logic [IW-1:0] idx, input logic [DW-1:0] v,
                          input logic mp, input logic [PW-1:0] tgt);
        wb_valid[p] = 1;
        wb_idx[p*IW +: IW] = idx;
        wb_value[p*DW +: DW] = v;
        wb_mispredict[p] = mp;
        wb_target[p*PW +: PW] = tgt;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 0;
        #3;
        n_chk++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
        n_chk++; if (alloc_idx !== 4'd0) begin n_fail++; $display("FAIL reset_alloc_idx got=%0d exp=0", alloc_idx); end
        n_chk++; if (ret_valid !== 2'b00 || ret_wr_en !== 2'b00) begin n_fail++; $display("FAIL reset_ret got=%b/%b exp=00/00", ret_valid, ret_wr_en); end
        n_chk++; if (st_valid !== 1'b0 || flush_valid !== 1'b0) begin n_fail++; $display("FAIL reset_st_flush got=%b/%b exp=0/0", st_valid, flush_valid); end
        n_chk++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got=%h exp=0", flush_pc); end
        n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        cyc();
        rst = 1;
    endtask

    task automatic test_fill;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1, 0, TW'(i), TW'(i));
            #1;
            n_chk++; if (alloc_idx !== 4'(i) || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_idx got=%0d rdy=%b exp=%0d rdy=1", alloc_idx, alloc_ready, i); end
            cyc();
        end
        idle_inputs();
        #1;
        n_chk++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count got=%0d exp=16", count); end
        n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got=%b exp=0", alloc_ready); end
    endtask

    task automatic test_out_of_order;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(1, 0, TW'(10 + i), TW'(20 + i));
            cyc();
        end
        idle_inputs();
        set_wb(0, 4'd2, 32'hAAAA, 0, 0);
        set_wb(1, 4'd2, 32'h2222, 0, 0);
        #1;
        n_chk++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_wait2 got=%b exp=00", ret_valid); end
        cyc(); idle_inputs();
        set_wb(0, 4'd1, 32'h1111, 0, 0);
        #1;
        n_chk++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_wait1 got=%b exp=00", ret_valid); end
        cyc(); idle_inputs();
        set_wb(1, 4'd0, 32'h1000, 0, 0);
        #1;
        n_chk++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_same_cycle_wb got=%b exp=00", ret_valid); end
        cyc(); idle_inputs();
        #1;
        n_chk++; if (ret_valid !== 2'b11 || ret_wr_en !== 2'b11) begin n_fail++; $display("FAIL ooo_dual got=%b/%b exp=11/11", ret_valid, ret_wr_en); end
        n_chk++; if (ret_dest !== {6'd11, 6'd10} || ret_free !== {6'd21, 6'd20}) begin n_fail++; $display("FAIL ooo_tags got=%h/%h exp=%h/%h", ret_dest, ret_free, {6'd11, 6'd10}, {6'd21, 6'd20}); end
        n_chk++; if (ret_value !== {32'h1111, 32'h1000}) begin n_fail++; $display("FAIL ooo_values got=%h exp=%h", ret_value, {32'h1111, 32'h1000}); end
        cyc();
        #1;
        n_chk++; if (ret_valid !== 2'b01 || ret_dest[TW-1:0] !== 6'd12) begin n_fail++; $display("FAIL ooo_third got=%b dest=%0d exp=01 dest=12", ret_valid, ret_dest[TW-1:0]); end
        n_chk++; if (ret_value[DW-1:0] !== 32'h2222) begin n_fail++; $display("FAIL ooo_high_port_wins got=%h exp=2222", ret_value[DW-1:0]); end
        cyc();
        #1;
        n_chk++; if (count !== 5'd0 || ret_valid !== 2'b00) begin n_fail++; $display("FAIL ooo_drained got=%0d/%b exp=0/00", count, ret_valid); end
    endtask

    task automatic test_store;
        apply_reset();
        set_alloc(0, 1, 0, 0); cyc();
        set_alloc(1, 0, 6'd5, 6'd7); cyc();
        idle_inputs();
        set_wb(0, 4'd0, 32'h0, 0, 0);
        set_wb(1, 4'd1, 32'h55, 0, 0);
        cyc(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (st_valid !== 1'b1 || ret_valid !== 2'b00) begin n_fail++; $display("FAIL store_stall got=%b/%b exp=1/00", st_valid, ret_valid); end
            cyc();
        end
        st_ready = 1;
        #1;
        n_chk++; if (ret_valid !== 2'b01 || ret_wr_en !== 2'b00) begin n_fail++; $display("FAIL store_commit got=%b/%b exp=01/00", ret_valid, ret_wr_en); end
        cyc();
        st_ready = 0;
        #1;
        n_chk++; if (count !== 5'd1 || st_valid !== 1'b0) begin n_fail++; $display("FAIL store_after got=%0d/%b exp=1/0", count, st_valid); end
        n_chk++; if (ret_valid !== 2'b01 || ret_wr_en !== 2'b01 || ret_dest[TW-1:0] !== 6'd5) begin n_fail++; $display("FAIL store_next_alu got=%b/%b/%0d exp=01/01/5", ret_valid, ret_wr_en, ret_dest[TW-1:0]); end
        cyc();
        #1;
        n_chk++; if (count !== 5'd0 || alloc_idx !== 4'd2) begin n_fail++; $display("FAIL store_drained got=%0d/%0d exp=0/2", count, alloc_idx); end
    endtask

    task automatic test_mispredict;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(1, 0, TW'(i + 1), TW'(i + 40));
            cyc();
        end
        idle_inputs();
        set_wb(0, 4'd0, 32'h10, 0, 0);
        set_wb(1, 4'd1, 32'h11, 1, 32'h100);
        cyc(); idle_inputs();
        set_wb(0, 4'd2, 32'h12, 0, 0);
        set_wb(1, 4'd3, 32'h13, 0, 0);
        set_alloc(1, 0, 6'd9, 6'd9);
        #1;
        n_chk++; if (ret_valid !== 2'b11 || flush_valid !== 1'b1) begin n_fail++; $display("FAIL mp_flush got=%b/%b exp=11/1", ret_valid, flush_valid); end
        n_chk++; if (flush_pc !== 32'h100) begin n_fail++; $display("FAIL mp_flush_pc got=%h exp=100", flush_pc); end
        n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL mp_alloc_blocked got=%b exp=0", alloc_ready); end
        cyc(); idle_inputs();
        #1;
        n_chk++; if (count !== 5'd0 || alloc_idx !== 4'd2) begin n_fail++; $display("FAIL mp_after got=%0d/%0d exp=0/2", count, alloc_idx); end
        n_chk++; if (flush_valid !== 1'b0 || ret_valid !== 2'b00 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL mp_quiet got=%b/%b/%b exp=0/00/1", flush_valid, ret_valid, alloc_ready); end
    endtask

    task automatic test_wrap;
        int exp_idx[4] = '{14, 15, 0, 1};
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            set_alloc(1, 0, TW'(i), 0);
            cyc();
        end
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            set_wb(0, IW'(2 * i), 32'h0, 0, 0);
            set_wb(1, IW'(2 * i + 1), 32'h0, 0, 0);
            cyc(); idle_inputs();
        end
        for (int n = 0; n < 40 && count != 0; n++) cyc();
        n_chk++; if (count !== 5'd0 || alloc_idx !== 4'd14) begin n_fail++; $display("FAIL wrap_drain got=%0d/%0d exp=0/14", count, alloc_idx); end
        for (int i = 0; i < 4; i++) begin
            set_alloc(1, 0, TW'(30 + i), TW'(50 + i));
            #1;
            n_chk++; if (alloc_idx !== IW'(exp_idx[i])) begin n_fail++; $display("FAIL wrap_idx got=%0d exp=%0d", alloc_idx, exp_idx[i]); end
            cyc();
        end
        idle_inputs();
        set_wb(0, 4'd14, 32'hE, 0, 0);
        cyc(); idle_inputs();
        set_alloc(1, 0, 6'd34, 6'd54);
        #1;
        n_chk++; if (ret_valid !== 2'b01 || ret_dest[TW-1:0] !== 6'd30 || alloc_idx !== 4'd2) begin n_fail++; $display("FAIL wrap_ret_alloc got=%b/%0d/%0d exp=01/30/2", ret_valid, ret_dest[TW-1:0], alloc_idx); end
        cyc(); idle_inputs();
        #1;
        n_chk++; if (count !== 5'd4) begin n_fail++; $display("FAIL wrap_count_const got=%0d exp=4", count); end
        set_wb(0, 4'd15, 32'hF, 0, 0);
        set_wb(1, 4'd0, 32'h0, 0, 0);
        cyc(); idle_inputs();
        set_alloc(1, 0, 6'd35, 6'd55);
        #1;
        n_chk++; if (ret_valid !== 2'b11 || ret_dest !== {6'd32, 6'd31} || ret_free !== {6'd52, 6'd51}) begin n_fail++; $display("FAIL wrap_dual got=%b/%h/%h exp=11/%h/%h", ret_valid, ret_dest, ret_free, {6'd32, 6'd31}, {6'd52, 6'd51}); end
        n_chk++; if (alloc_idx !== 4'd3) begin n_fail++; $display("FAIL wrap_alloc3 got=%0d exp=3", alloc_idx); end
        cyc(); idle_inputs();
        #1;
        n_chk++; if (count !== 5'd3) begin n_fail++; $display("FAIL wrap_count got=%0d exp=3", count); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1, 0, TW'(i), 0);
            cyc();
        end
        idle_inputs();
        set_wb(0, 4'd0, 32'h1, 0, 0);
        cyc(); idle_inputs();
        #1;
        n_chk++; if (count !== 5'd5 || ret_valid !== 2'b01) begin n_fail++; $display("FAIL mid_before got=%0d/%b exp=5/01", count, ret_valid); end
        set_wb(1, 4'd1, 32'h2, 0, 0);
        set_alloc(1, 0, 6'd7, 6'd7);
        #1;
        rst = 0;
        #1;
        n_chk++; if (count !== 5'd0 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin n_fail++; $display("FAIL mid_reset got=%0d/%b/%0d exp=0/1/0", count, alloc_ready, alloc_idx); end
        n_chk++; if (ret_valid !== 2'b00 || ret_wr_en !== 2'b00 || st_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ret got=%b/%b/%b exp=00/00/0", ret_valid, ret_wr_en, st_valid); end
        idle_inputs();
        cyc();
        rst = 1;
        set_alloc(1, 0, 6'd9, 6'd9);
        #1;
        n_chk++; if (alloc_idx !== 4'd0) begin n_fail++; $display("FAIL mid_first_alloc got=%0d exp=0", alloc_idx); end
        cyc(); idle_inputs();
        #1;
        n_chk++; if (count !== 5'd1 || ret_valid !== 2'b00) begin n_fail++; $display("FAIL mid_after got=%0d/%b exp=1/00", count, ret_valid); end
    endtask

    initial begin
        idle_inputs();
        cyc();
        test_reset();
        test_fill();
        test_out_of_order();
        test_store();
        test_mispredict();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_retire_multi.md
ROB_RETIRE_MULTI -- requirements
Module: rob_retire_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 16, ROB entries (power of 2, >=4); IDX_W = $clog2(DEPTH).
REQ-002 SHALL have parameter WB_PORTS, default 2, number of writeback ports.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 2, max entries retired per cycle (1..4).
REQ-004 SHALL have parameters DATA_W default 32, TAG_W default 6 (phys reg addr), PC_W default 32.
REQ-005 SHALL have ports:
 clk  in  1  clock, rising edge.
 rst  in  1  asynchronous, active-low reset.
 alloc_valid  in  1  rename requests an entry.
 alloc_ready  out  1  entry available.
 alloc_has_dest / alloc_is_store  in  1 each  entry writes a register / entry is a store.
 alloc_dest / alloc_old  in  TAG_W each  new phys dest / previous mapping to free.
 alloc_idx  out  IDX_W  index granted (current tail).
 wb_valid  in  WB_PORTS  per-port result strobe.
 wb_idx  in  WB_PORTS*IDX_W  target entry.
 wb_value  in  WB_PORTS*DATA_W  result.
 wb_mispredict  in  WB_PORTS  entry is a mispredicted control transfer.
 wb_target  in  WB_PORTS*PC_W  redirect PC.
 ret_valid  out  RETIRE_WIDTH  lane k retires this cycle.
 ret_dest / ret_free  out  RETIRE_WIDTH*TAG_W each  RF write addr / tag returned to free list.
 ret_value  out  RETIRE_WIDTH*DATA_W  RF write data.
 ret_wr_en  out  RETIRE_WIDTH  lane k writes RF and clears busy bit.
 st_valid  out  1  head store ready to commit.
 st_ready  in  1  memory accepts store.
 flush_valid  out  1  mispredict retiring; squash younger.
 flush_pc  out  PC_W  redirect target.
 count  out  IDX_W+1  occupied entries.

Function
REQ-006 SHALL store per entry: valid, done, has_dest, is_store, dest, old, value, mispredict, target.
REQ-007 SHALL keep head/tail pointers of IDX_W+1 bits (wrap bit); count = tail - head; full when count == DEPTH; pointer arithmetic modulo 2^(IDX_W+1).
REQ-008 SHALL drive alloc_ready = (count != DEPTH) && !flush_valid; alloc_idx = tail[IDX_W-1:0].
REQ-009 SHALL on alloc_valid && alloc_ready write entry at tail with done=0, mispredict=0, and increment tail next edge.
REQ-010 SHALL on wb_valid[p] for a valid entry set done=1 and capture value, mispredict, target; wb to invalid entries SHALL be ignored; same idx on two ports same cycle: highest port wins.
REQ-011 SHALL evaluate retire lanes combinationally from registered state: lane k eligible iff k < count, entries head..head+k all done, no lane j<k has mispredict or is_store.
REQ-012 SHALL restrict stores to lane 0: st_valid = head valid && done && is_store; store retires only when st_valid && st_ready; lanes >=1 blocked that cycle.
REQ-013 SHALL drive ret_wr_en[k] = ret_valid[k] && has_dest && !is_store; ret_free[k] = old, meaningful only when ret_wr_en[k].
REQ-014 SHALL, when a retiring lane's entry has mispredict, assert flush_valid with flush_pc = its target, same cycle; later lanes SHALL NOT retire.
REQ-015 SHALL on flush clear all entries' valid, set head = tail = retiring pointer + 1, count = 0 next edge; alloc in the flush cycle SHALL be rejected.
REQ-016 SHALL advance head by number of retired lanes R; count next = count + alloc_fire - R, simultaneous alloc and retire included.
REQ-017 SHALL clear valid and done of retired entries on the retire edge.
REQ-018 SHALL not retire a result written back in the same cycle; it becomes eligible the next cycle.
REQ-019 SHALL permit alloc when full only in the cycle after retire frees an entry (alloc_ready from registered count).

Reset
REQ-020 SHALL on rst low asynchronously clear head, tail, count, all valid/done bits; outputs then: alloc_ready=1, alloc_idx=0, ret_valid=0, ret_wr_en=0, st_valid=0, flush_valid=0, flush_pc=0, count=0.
REQ-021 SHALL discard in-flight allocations and writebacks on reset mid-operation; first post-reset alloc gets idx 0.

Verification
REQ-022 Alloc 16 entries back-to-back (DEPTH=16) -> alloc_idx 0..15, count=16, alloc_ready=0 on cycle 17.
REQ-023 Alloc idx0,1,2; wb idx2 then idx1 then idx0 -> no retire until idx0 done; next cycle ret_valid=2'b11 for 0,1; following cycle lane0 retires 2; count 0.
REQ-024 Alloc store at idx0, st_ready=0 for 3 cycles after done -> st_valid=1, no retire; st_ready=1 -> retires, head=1.
REQ-025 Alloc idx0..3, wb all, idx1 mispredict target 0x100 -> ret_valid=2'b11, flush_valid=1, flush_pc=0x100; next cycle count=0, head=tail=2.
REQ-026 Fill to tail wrap (head=14, tail=18 mod 32) and retire/alloc simultaneously -> count constant, indices 14,15,0,1 correct.
REQ-027 Drop rst mid-stream with count=5 -> outputs at reset values immediately, next alloc_idx=0.
